// File: rtl/lfsr_gen_if.sv
// Bus bundle for lfsr_gen: step/load controls in, LFSR state and status out.
// Latency: none, wires only.
// Backpressure: none; the consumer samples every cycle.
//
// Signals (names from the generator's point of view):
//   en_i       advance one step this cycle
//   load_i     load seed_in_i this cycle (overrides en_i)
//   seed_in_i  runtime seed, WIDTH bits
//   out_o      current LFSR state
//   bit_out_o  serial output, MSB of out_o
//   wrap_o     one-cycle pulse when the state returns to its start value
//   period_o   step count of the last completed orbit
//   seed_err_o sticky flag, a zero seed was rejected
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] seed_in_i;
    logic [WIDTH-1:0] out_o;
    logic             bit_out_o;
    logic             wrap_o;
    logic [WIDTH-1:0] period_o;
    logic             seed_err_o;

    // Stimulus side: drives the controls, observes the state.
    modport master (
        output en_i, load_i, seed_in_i,
        input  out_o, bit_out_o, wrap_o, period_o, seed_err_o
    );

    // Generator side.
    modport slave (
        input  en_i, load_i, seed_in_i,
        output out_o, bit_out_o, wrap_o, period_o, seed_err_o
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-seed guard and period measurement.
// Latency: out, wrap, period, seed_err update one cycle after the en/load sample.
// Backpressure: none; load beats en, en beats hold, every cycle is accepted.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    lfsr_gen_if.slave (en/load/seed_in in; out/bit_out/wrap/period/seed_err out)
module lfsr_gen #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
    parameter bit               MODE  = 1'b0,      // 0 = Fibonacci, 1 = Galois
    parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
    input  logic     clk,
    input  logic     rst_n,
    lfsr_gen_if.slave bus
);

    // Parameter legality, rejected at elaboration.
    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be within 3..32");
        end
        if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
            $error("lfsr_gen: TAPS[WIDTH-1] must be 1");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: SEED must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0] out_q,    out_d;
    logic [WIDTH-1:0] start_q,  start_d;   // value the orbit must return to
    logic [WIDTH-1:0] count_q,  count_d;   // enabled steps since start
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] step_w;

    // One LFSR step from the current state.
    generate
        if (MODE == 1'b0) begin : g_fib
            logic fb_w;
            assign fb_w   = ^(out_q & TAPS);
            assign step_w = {out_q[WIDTH-2:0], fb_w};
        end else begin : g_gal
            assign step_w = (out_q >> 1) ^ (out_q[0] ? TAPS : '0);
        end
    endgenerate

    always_comb begin
        out_d    = out_q;
        start_d  = start_q;
        count_d  = count_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        err_d    = err_q;

        if (bus.load_i) begin
            // A zero seed would lock the register at zero; fall back to SEED.
            if (bus.seed_in_i != '0) begin
                out_d   = bus.seed_in_i;
                start_d = bus.seed_in_i;
                err_d   = 1'b0;
            end else begin
                out_d   = SEED;
                start_d = SEED;
                err_d   = 1'b1;
            end
            count_d = '0;
        end else if (bus.en_i) begin
            out_d = step_w;
            // The orbit is at most 2^WIDTH-1 long, so count+1 always fits.
            if (step_w == start_q) begin
                wrap_d   = 1'b1;
                period_d = count_q + WIDTH'(1);
                count_d  = '0;
            end else begin
                count_d  = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= SEED;
            start_q  <= SEED;
            count_q  <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            start_q  <= start_d;
            count_q  <= count_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_o      = out_q;
    assign bus.bit_out_o  = out_q[WIDTH-1];
    assign bus.wrap_o     = wrap_q;
    assign bus.period_o   = period_q;
    assign bus.seed_err_o = err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: three instances (4-bit Fibonacci, 4-bit Galois, 8-bit Galois)
// share en/load, a reference model predicts each cycle, a monitor compares after every clock.
// Directed phases follow the documented sequences, then randomized traffic, then async reset.
module tb_lfsr_gen;

    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    lfsr_gen_if #(.WIDTH(4)) if_f ();
    lfsr_gen_if #(.WIDTH(4)) if_g ();
    lfsr_gen_if #(.WIDTH(8)) if_w ();

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(1'b0), .SEED(4'b0001))
        dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(1'b1), .SEED(4'b0001))
        dut_g (.clk(clk), .rst_n(rst_n), .bus(if_g));
    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(1'b1), .SEED(8'h5A))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w));

    // Observed outputs, widened to a common size.
    logic [31:0] act_out    [3];
    logic [31:0] act_period [3];
    logic        act_wrap   [3];
    logic        act_err    [3];
    logic        act_bit    [3];

    assign act_out[0] = 32'(if_f.out_o);
    assign act_out[1] = 32'(if_g.out_o);
    assign act_out[2] = 32'(if_w.out_o);
    assign act_period[0] = 32'(if_f.period_o);
    assign act_period[1] = 32'(if_g.period_o);
    assign act_period[2] = 32'(if_w.period_o);
    assign act_wrap[0] = if_f.wrap_o;
    assign act_wrap[1] = if_g.wrap_o;
    assign act_wrap[2] = if_w.wrap_o;
    assign act_err[0] = if_f.seed_err_o;
    assign act_err[1] = if_g.seed_err_o;
    assign act_err[2] = if_w.seed_err_o;
    assign act_bit[0] = if_f.bit_out_o;
    assign act_bit[1] = if_g.bit_out_o;
    assign act_bit[2] = if_w.bit_out_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0][31:0] out;
        logic [2:0]       bit_out;
        logic [2:0]       wrap;
        logic [2:0][31:0] period;
        logic [2:0]       seed_err;
    } exp_t;

    exp_t sb [$];

    // Instance configurations.
    int     PW [3] = '{4, 4, 8};
    longint PT [3] = '{64'h9, 64'hC, 64'hB8};
    int     PM [3] = '{0, 1, 1};
    longint PS [3] = '{64'h1, 64'h1, 64'h5A};

    // Reference model state.
    longint m_out [3], m_start [3], m_count [3], m_period [3];
    bit     m_wrap [3], m_err [3];

    // Documented output sequences (first entry is the reset state).
    logic [3:0] fib_tbl [16] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] gal_tbl [16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic longint next_state(int k, longint s);
        longint mask;
        longint fb;
        mask = (longint'(1) << PW[k]) - 1;
        if (PM[k] == 0) begin
            fb = longint'($countones(s & PT[k]) % 2);
            return ((s * 2) + fb) & mask;
        end
        return (s / 2) ^ ((s % 2 == 1) ? PT[k] : 64'h0);
    endfunction

    function automatic void model_reset(int k);
        m_out[k]    = PS[k];
        m_start[k]  = PS[k];
        m_count[k]  = 0;
        m_period[k] = 0;
        m_wrap[k]   = 1'b0;
        m_err[k]    = 1'b0;
    endfunction

    function automatic void model_apply(int k, bit en, bit ld, longint sd);
        longint nx;
        m_wrap[k] = 1'b0;
        if (ld) begin
            if (sd != 0) begin
                m_out[k] = sd; m_start[k] = sd; m_err[k] = 1'b0;
            end else begin
                m_out[k] = PS[k]; m_start[k] = PS[k]; m_err[k] = 1'b1;
            end
            m_count[k] = 0;
        end else if (en) begin
            nx = next_state(k, m_out[k]);
            m_out[k] = nx;
            if (nx == m_start[k]) begin
                m_wrap[k] = 1'b1; m_period[k] = m_count[k] + 1; m_count[k] = 0;
            end else begin
                m_count[k] = m_count[k] + 1;
            end
        end
    endfunction

    // Compare live outputs against the model immediately (reset checks).
    task automatic check_now(int k, string tag);
        chk($sformatf("%s_out%0d", tag, k),    act_out[k],    32'(m_out[k]));
        chk($sformatf("%s_wrap%0d", tag, k),   32'(act_wrap[k]), 32'(m_wrap[k]));
        chk($sformatf("%s_period%0d", tag, k), act_period[k], 32'(m_period[k]));
        chk($sformatf("%s_err%0d", tag, k),    32'(act_err[k]),  32'(m_err[k]));
    endtask

    // Issue one cycle of stimulus and push the predicted response.
    task automatic drive(bit en, bit ld, logic [7:0] sd, int tidx);
        exp_t e;
        e = '0;
        @(negedge clk);
        if_f.en_i = en; if_g.en_i = en; if_w.en_i = en;
        if_f.load_i = ld; if_g.load_i = ld; if_w.load_i = ld;
        if_f.seed_in_i = sd[3:0]; if_g.seed_in_i = sd[3:0]; if_w.seed_in_i = sd;
        for (int k = 0; k < 3; k++) begin
            model_apply(k, en, ld, (k == 2) ? longint'(sd) : longint'(sd[3:0]));
            e.out[k]      = 32'(m_out[k]);
            e.bit_out[k]  = ((m_out[k] >> (PW[k] - 1)) & 1) != 0;
            e.wrap[k]     = m_wrap[k];
            e.period[k]   = 32'(m_period[k]);
            e.seed_err[k] = m_err[k];
        end
        if (tidx >= 0) begin
            e.out[0] = 32'(fib_tbl[tidx]);
            e.out[1] = 32'(gal_tbl[tidx]);
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every clock, compare DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("out%0d", k),    act_out[k],       e.out[k]);
                    chk($sformatf("bit%0d", k),    32'(act_bit[k]),  32'(e.bit_out[k]));
                    chk($sformatf("wrap%0d", k),   32'(act_wrap[k]), 32'(e.wrap[k]));
                    chk($sformatf("period%0d", k), act_period[k],    e.period[k]);
                    chk($sformatf("err%0d", k),    32'(act_err[k]),  32'(e.seed_err[k]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;
        bit en_r, ld_r;
        logic [7:0] sd_r;

        rst_n = 1'b0;
        if_f.en_i = 1'b0; if_g.en_i = 1'b0; if_w.en_i = 1'b0;
        if_f.load_i = 1'b0; if_g.load_i = 1'b0; if_w.load_i = 1'b0;
        if_f.seed_in_i = '0; if_g.seed_in_i = '0; if_w.seed_in_i = '0;

        // Reset state.
        #12;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            check_now(k, "rst");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Documented sequences: 15 steps back to 0001 on both 4-bit forms.
        for (int i = 1; i < 16; i++) drive(1'b1, 1'b0, 8'h00, i);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("period_fib_15", act_period[0], 32'd15);
        chk("period_gal_15", act_period[1], 32'd15);

        // Mid-sequence load of 1010, then a full orbit back to it.
        drive(1'b1, 1'b0, 8'h00, -1);
        drive(1'b1, 1'b0, 8'h00, -1);
        drive(1'b0, 1'b1, 8'h3A, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("load_out_a", act_out[0], 32'hA);
        drive(1'b1, 1'b0, 8'h00, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("load_next_5", act_out[0], 32'h5);
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, 8'h00, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("reload_back_a", act_out[0], 32'hA);
        chk("reload_period", act_period[0], 32'd15);

        // Zero seed rejected, flag sticky across steps, cleared by a good load.
        drive(1'b0, 1'b1, 8'h00, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("zero_seed_out", act_out[0], 32'h1);
        chk("zero_seed_err", 32'(act_err[0]), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("zero_seed_err_held", 32'(act_err[0]), 32'd1);
        drive(1'b0, 1'b1, 8'h06, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("good_seed_err_clr", 32'(act_err[0]), 32'd0);
        chk("good_seed_out", act_out[0], 32'h6);

        // en toggling every cycle: 15 enabled steps, one wrap.
        wraps = 0;
        for (int i = 0; i <= 30; i++) begin
            drive((i < 30) && (i % 2 == 0), 1'b0, 8'h00, -1);
            wraps += int'(act_wrap[0]);
        end
        drain();
        chk("toggle_wraps", 32'(wraps), 32'd1);
        chk("toggle_period", act_period[0], 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            en_r = ($urandom % 4) != 0;
            ld_r = ($urandom % 64) == 0;
            sd_r = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            drive(en_r, ld_r, sd_r, -1);
        end
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();

        // Asynchronous reset mid-cycle with out = 1101.
        drive(1'b0, 1'b1, 8'hED, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();
        chk("pre_arst_out", act_out[0], 32'hD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            check_now(k, "arst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) drive(($urandom % 3) != 0, 1'b0, 8'h00, -1);
        drive(1'b0, 1'b0, 8'h00, -1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register generator: the generalised successor of the fixed 4-bit LFSR. It supports configurable width, tap polynomial and Fibonacci/Galois form, with clock enable, runtime seed loading, all-zero seed protection and sequence-period measurement. It sits as a pseudo-random source for test-pattern generation, scramblers and BIST logic.

## Interface
- WIDTH, 4: register width, legal 3..32.
- TAPS, 4'b1001: feedback mask, WIDTH bits; bit WIDTH-1 must be 1.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- SEED, 4'b0001: reset/fallback state, WIDTH bits, must be nonzero.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance one step per cycle when high.
- load  in  1  load seed_in this cycle; overrides en.
- seed_in  in  WIDTH  runtime seed.
- out  out  WIDTH  current LFSR state (registered).
- bit_out  out  1  serial output = out[WIDTH-1] (combinational from out).
- wrap  out  1  one-cycle pulse: the state has returned to the start value.
- period  out  WIDTH  step count of the last completed cycle.
- seed_err  out  1  sticky flag: a zero seed was rejected.

## Operation
- Illegal parameters cause an elaboration error: WIDTH outside 3..32, TAPS[WIDTH-1]=0, or SEED=0.
- Step function, with s = out:
  - Fibonacci: fb = XOR of s[i] over all i with TAPS[i]=1; next = {s[WIDTH-2:0], fb}.
  - Galois: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Internal registers:
  - start (WIDTH): the value to which the sequence must return.
  - count (WIDTH): steps taken since start.
- Priority per cycle: load > en > hold.
- load=1, seed_in≠0: out ← seed_in, start ← seed_in, count ← 0, wrap ← 0, seed_err ← 0. period is held.
- load=1, seed_in=0: out ← SEED, start ← SEED, count ← 0, wrap ← 0, seed_err ← 1. The all-zero lock-up state is therefore unreachable.
- en=1, load=0: out ← next.
  - If next == start: wrap ← 1, period ← count+1, count ← 0.
  - Otherwise: wrap ← 0, count ← count+1.
- en=0, load=0: out, start, count and period hold; wrap ← 0.
- count never overflows. The step function is a permutation of the nonzero states, so the orbit returns to start within 2^WIDTH−1 steps.
- period reads 0 until the first wrap after reset.

## Timing
- Reset, asynchronous on rst falling, with rst released synchronously to clk by the system:
  - out = SEED, start = SEED, count = 0, period = 0, wrap = 0, seed_err = 0.
- First step occurs on the first rising edge with rst=1 and en=1.
- Latency:
  - out changes one cycle after the en/load sample.
  - wrap, period and seed_err are registered and valid in the same cycle as the out value that caused them.
- wrap is high for exactly one cycle per return to start, and only after an enabled step. A load that happens to equal the current out does not pulse wrap.
- Back-to-back load cycles: each load restarts count. The last one wins.
- Reset asserted mid-sequence clears everything immediately, independent of clk.
- Enable gaps do not affect period; only enabled steps are counted.

## Test plan
- Defaults (Fibonacci, TAPS=1001, SEED=0001), rst low 15 ns, then en=1 for 16 cycles:
  - out must follow 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001.
  - wrap is high only on the second 0001; period becomes 15.
- MODE=1, TAPS=1100, seed 0001:
  - out must follow 0001, 1100, 0110, 0011, 1101, 1010, 0101, 1110, 0111, 1111, 1011, 1001, 1000, 0100, 0010, 0001.
  - wrap pulses once; period = 15.
- Mid-sequence load of 1010 (Fibonacci):
  - Next out = 1010, then 0101.
  - wrap pulses when out returns to 1010 after 15 steps; period = 15.
- Load seed_in=0000:
  - out = 0001 and seed_err = 1, held across steps.
  - A later load of 0110 clears seed_err.
- Toggle en 1/0 every cycle for 30 cycles:
  - out advances only on enabled cycles.
  - wrap pulses exactly once; period = 15.
- Assert rst asynchronously mid-cycle with out = 1101:
  - out = 0001, period = 0, wrap = 0 immediately, before the next clk edge.
